hssthp_fifo_clr_ctrl: RTL and testbench

- Parametrised successor to the per-quad HSSTHP RX FIFO-clear generator.
- Supports N lanes split into equal bonding groups of 1/2/4/8 lanes. Each group runs its own FSM that issues a fixed-width clear pulse after CDR alignment and lane-done.
- Per-group bypass passes user clear requests through; a watchdog aborts stalled groups.
- Sits between the HSSTHP reset sequencer and the PCS FIFO clear pins.

---
 rtl/hssthp_fifo_clr_ctrl_pkg.sv | 29 ++
 rtl/hssthp_fifo_clr_ctrl_if.sv | 35 +++
 rtl/hssthp_fifo_clr_ctrl_grp_fsm.sv | 158 +++++++++++++++
 rtl/hssthp_fifo_clr_ctrl.sv | 75 +++++++
 tb/tb_hssthp_fifo_clr_ctrl.sv | 172 +++++++++++++++++
 5 files changed

// File: rtl/hssthp_fifo_clr_ctrl_pkg.sv
// Shared types and helpers for the HSSTHP RX FIFO-clear controller.
// Optional statistics build: HSSTHP_FIFO_CLR_STATS_EN.
package hssthp_fifo_clr_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WAIT_DONE = 3'd1,
    SETTLE    = 3'd2,
    CLEAR     = 3'd3,
    DONE      = 3'd4
  } clr_state_e;

  localparam int STAT_W = 8;

  // Width of a counter that must hold the largest of three limits without wrapping.
  function automatic int clog2_max(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return $clog2(m + 1);
  endfunction

  // Bonding groups are 1, 2, 4 or 8 lanes wide.
  function automatic bit grp_size_ok(input int gs);
    return (gs == 1) || (gs == 2) || (gs == 4) || (gs == 8);
  endfunction

endpackage

// File: rtl/hssthp_fifo_clr_ctrl_if.sv
// Lane-side bundle between the reset sequencer, the controller and the PCS clear pins.
// With HSSTHP_FIFO_CLR_STATS_EN the per-group clear counters ride along.
interface hssthp_fifo_clr_ctrl_if #(
  parameter int NUM_LANES = 4,
  parameter int NG        = 2
);
  logic [NUM_LANES-1:0] i_lane_srst;
  logic [NUM_LANES-1:0] i_cdr_align;
  logic [NUM_LANES-1:0] i_rxlane_done;
  logic [NUM_LANES-1:0] i_fifo_clr_req;
  logic [NUM_LANES-1:0] o_fifo_clr_en;
  logic [NG-1:0]        o_grp_timeout;
  logic [NG-1:0]        o_grp_busy;
`ifdef HSSTHP_FIFO_CLR_STATS_EN
  logic [NG*8-1:0]      o_clr_cnt;

  modport master (
    output i_lane_srst, i_cdr_align, i_rxlane_done, i_fifo_clr_req,
    input  o_fifo_clr_en, o_grp_timeout, o_grp_busy, o_clr_cnt
  );
  modport slave (
    input  i_lane_srst, i_cdr_align, i_rxlane_done, i_fifo_clr_req,
    output o_fifo_clr_en, o_grp_timeout, o_grp_busy, o_clr_cnt
  );
`else
  modport master (
    output i_lane_srst, i_cdr_align, i_rxlane_done, i_fifo_clr_req,
    input  o_fifo_clr_en, o_grp_timeout, o_grp_busy
  );
  modport slave (
    input  i_lane_srst, i_cdr_align, i_rxlane_done, i_fifo_clr_req,
    output o_fifo_clr_en, o_grp_timeout, o_grp_busy
  );
`endif
endinterface

// File: rtl/hssthp_fifo_clr_ctrl_grp_fsm.sv
// One bonding group: CDR/lane-done sequencing, fixed-width FIFO clear pulse,
// WAIT_DONE watchdog and bypass path. HSSTHP_FIFO_CLR_STATS_EN adds a clear counter.
//
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   IDLE      | waiting for a CDR-align rising edge on any group lane
//   WAIT_DONE | waiting for every group lane_done; watchdog running
//   SETTLE    | all lanes done, counting SETTLE_CYC before clearing
//   CLEAR     | FIFO clear asserted on all group lanes for CLR_PULSE_CYC
//   DONE      | clear issued; re-arm on new edge, fall back when CDR lost
module hssthp_fifo_clr_grp_fsm
  import hssthp_fifo_clr_pkg::*;
#(
  parameter int GROUP_SIZE    = 2,
  parameter int SETTLE_CYC    = 16,
  parameter int CLR_PULSE_CYC = 4,
  parameter int TIMEOUT_CYC   = 65535,
  parameter bit BYPASS        = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [GROUP_SIZE-1:0] lane_srst,
  input  logic [GROUP_SIZE-1:0] cv,
  input  logic [GROUP_SIZE-1:0] cv_rise,
  input  logic [GROUP_SIZE-1:0] lane_done,
  input  logic [GROUP_SIZE-1:0] clr_req,
  output logic [GROUP_SIZE-1:0] clr_en,
  output logic                  timeout,
  output logic                  busy
`ifdef HSSTHP_FIFO_CLR_STATS_EN
  ,
  output logic [STAT_W-1:0]     clr_cnt
`endif
);

  localparam int            CW          = clog2_max(SETTLE_CYC, CLR_PULSE_CYC, TIMEOUT_CYC);
  localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYC - 1);
  localparam logic [CW-1:0] PULSE_LAST  = CW'(CLR_PULSE_CYC - 1);
  localparam logic [CW-1:0] TO_LAST     = CW'(TIMEOUT_CYC - 1);
  localparam logic [CW-1:0] CNT_MAX     = '1;

  clr_state_e            state, state_nxt;
  logic [CW-1:0]         cnt, cnt_nxt, cnt_inc;
  logic                  srst_any, all_done, any_rise, any_cv;
  logic [GROUP_SIZE-1:0] clr_d;
  logic                  to_d;

  assign srst_any = |lane_srst;
  assign all_done = &lane_done;
  assign any_rise = |cv_rise;
  assign any_cv   = |cv;
  assign cnt_inc  = (cnt == CNT_MAX) ? cnt : cnt + CW'(1);
  assign busy     = (state != IDLE) && (state != DONE);

  // State and counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next-state and counter update; soft reset and bypass pin the FSM in IDLE.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt_inc;
    if (BYPASS || srst_any) begin
      state_nxt = IDLE;
      cnt_nxt   = '0;
    end else begin
      unique case (state)
        IDLE: begin
          cnt_nxt = '0;
          if (any_rise) state_nxt = WAIT_DONE;
        end
        WAIT_DONE: begin
          if (all_done) begin
            state_nxt = SETTLE;
            cnt_nxt   = '0;
          end else if (cnt == TO_LAST) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
          end
        end
        SETTLE: begin
          if (!all_done) begin
            state_nxt = WAIT_DONE;
            cnt_nxt   = '0;
          end else if (cnt == SETTLE_LAST) begin
            state_nxt = CLEAR;
            cnt_nxt   = '0;
          end
        end
        CLEAR: begin
          if (cnt == PULSE_LAST) begin
            state_nxt = DONE;
            cnt_nxt   = '0;
          end
        end
        DONE: begin
          cnt_nxt = '0;
          if (any_rise)     state_nxt = WAIT_DONE;
          else if (!any_cv) state_nxt = IDLE;
        end
        default: begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end
      endcase
    end
  end

  // Output decode ahead of the output register; soft reset forces the clear low.
  always_comb begin
    clr_d = '0;
    to_d  = 1'b0;
    if (!srst_any) begin
      if (BYPASS)              clr_d = clr_req;
      else if (state == CLEAR) clr_d = '1;
      to_d = !BYPASS && (state == WAIT_DONE) && !all_done && (cnt == TO_LAST);
    end
  end

  // Registered clear and watchdog outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clr_en  <= '0;
      timeout <= 1'b0;
    end else begin
      clr_en  <= clr_d;
      timeout <= to_d;
    end
  end

`ifdef HSSTHP_FIFO_CLR_STATS_EN
  logic req_or_d;
  logic bump;

  assign bump = BYPASS ? ((|clr_req) && !req_or_d)
                       : ((state_nxt == CLEAR) && (state != CLEAR));

  // Saturating count of issued clears (CLEAR entries or bypass request edges).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clr_cnt  <= '0;
      req_or_d <= 1'b0;
    end else begin
      req_or_d <= |clr_req;
      if (srst_any)                    clr_cnt <= '0;
      else if (bump && (clr_cnt != '1)) clr_cnt <= clr_cnt + STAT_W'(1);
    end
  end
`endif

endmodule

// File: rtl/hssthp_fifo_clr_ctrl.sv
// HSSTHP RX FIFO-clear controller: lane RX-enable masking, CDR-align edge
// detection and one sequencing FSM per bonding group.
// Optional per-group clear statistics: HSSTHP_FIFO_CLR_STATS_EN.
module hssthp_fifo_clr_ctrl
  import hssthp_fifo_clr_pkg::*;
#(
  parameter int                               NUM_LANES     = 4,
  parameter int                               GROUP_SIZE    = 2,
  parameter logic [NUM_LANES-1:0]             LANE_RX_EN    = {NUM_LANES{1'b1}},
  parameter logic [NUM_LANES/GROUP_SIZE-1:0]  GROUP_BYPASS  = '0,
  parameter int                               SETTLE_CYC    = 16,
  parameter int                               CLR_PULSE_CYC = 4,
  parameter int                               TIMEOUT_CYC   = 65535
) (
  input  logic                   clk,
  input  logic                   rst_n,
  hssthp_fifo_clr_ctrl_if.slave  bus
);

  localparam int NG = NUM_LANES / GROUP_SIZE;

  if (!grp_size_ok(GROUP_SIZE) || ((NUM_LANES % GROUP_SIZE) != 0) ||
      (NUM_LANES < 1) || (NUM_LANES > 16)) begin : g_bad_param
    $error("hssthp_fifo_clr_ctrl: illegal NUM_LANES=%0d / GROUP_SIZE=%0d", NUM_LANES, GROUP_SIZE);
  end

  logic [NUM_LANES-1:0] cv, cv_d, cv_rise;
  logic [NUM_LANES-1:0] clr_en_w;
  logic [NG-1:0]        timeout_w, busy_w;
`ifdef HSSTHP_FIFO_CLR_STATS_EN
  logic [NG*8-1:0]      clr_cnt_w;
  assign bus.o_clr_cnt = clr_cnt_w;
`endif

  assign cv      = bus.i_cdr_align & LANE_RX_EN;
  assign cv_rise = cv & ~cv_d;

  assign bus.o_fifo_clr_en = clr_en_w;
  assign bus.o_grp_timeout = timeout_w;
  assign bus.o_grp_busy    = busy_w;

  // One-cycle delay of the masked CDR-align for rising-edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cv_d <= '0;
    else        cv_d <= cv;
  end

  for (genvar g = 0; g < NG; g++) begin : g_grp
    localparam int LO = g * GROUP_SIZE;

    hssthp_fifo_clr_grp_fsm #(
      .GROUP_SIZE    (GROUP_SIZE),
      .SETTLE_CYC    (SETTLE_CYC),
      .CLR_PULSE_CYC (CLR_PULSE_CYC),
      .TIMEOUT_CYC   (TIMEOUT_CYC),
      .BYPASS        (GROUP_BYPASS[g])
    ) u_fsm (
      .clk       (clk),
      .rst_n     (rst_n),
      .lane_srst (bus.i_lane_srst[LO +: GROUP_SIZE]),
      .cv        (cv[LO +: GROUP_SIZE]),
      .cv_rise   (cv_rise[LO +: GROUP_SIZE]),
      .lane_done (bus.i_rxlane_done[LO +: GROUP_SIZE]),
      .clr_req   (bus.i_fifo_clr_req[LO +: GROUP_SIZE]),
      .clr_en    (clr_en_w[LO +: GROUP_SIZE]),
      .timeout   (timeout_w[g]),
      .busy      (busy_w[g])
`ifdef HSSTHP_FIFO_CLR_STATS_EN
      ,
      .clr_cnt   (clr_cnt_w[g*8 +: 8])
`endif
    );
  end

endmodule

// File: tb/tb_hssthp_fifo_clr_ctrl.sv
// Directed bench for hssthp_fifo_clr_ctrl across four parameter sets.
// Counter checks are compiled in with HSSTHP_FIFO_CLR_STATS_EN.
module tb_hssthp_fifo_clr_ctrl;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_chk = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  hssthp_fifo_clr_ctrl_if #(.NUM_LANES(4), .NG(2)) bus0 ();
  hssthp_fifo_clr_ctrl_if #(.NUM_LANES(4), .NG(1)) bus1 ();
  hssthp_fifo_clr_ctrl_if #(.NUM_LANES(4), .NG(2)) bus2 ();
  hssthp_fifo_clr_ctrl_if #(.NUM_LANES(4), .NG(4)) bus3 ();

  hssthp_fifo_clr_ctrl #(.NUM_LANES(4), .GROUP_SIZE(2)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .bus(bus0));
  hssthp_fifo_clr_ctrl #(.NUM_LANES(4), .GROUP_SIZE(4), .TIMEOUT_CYC(100)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .bus(bus1));
  hssthp_fifo_clr_ctrl #(.NUM_LANES(4), .GROUP_SIZE(2), .GROUP_BYPASS(2'b10)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .bus(bus2));
  hssthp_fifo_clr_ctrl #(.NUM_LANES(4), .GROUP_SIZE(1), .LANE_RX_EN(4'b1110)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .bus(bus3));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    int found, seen, n_to, to_k;
    bus0.i_lane_srst = '0; bus0.i_cdr_align = '0; bus0.i_rxlane_done = '0; bus0.i_fifo_clr_req = '0;
    bus1.i_lane_srst = '0; bus1.i_cdr_align = '0; bus1.i_rxlane_done = '0; bus1.i_fifo_clr_req = '0;
    bus2.i_lane_srst = '0; bus2.i_cdr_align = '0; bus2.i_rxlane_done = '0; bus2.i_fifo_clr_req = '0;
    bus3.i_lane_srst = '0; bus3.i_cdr_align = '0; bus3.i_rxlane_done = '0; bus3.i_fifo_clr_req = '0;

    // Reset state with inputs active on the bypass DUT.
    bus2.i_fifo_clr_req = 4'b1111;
    tick(3);
    chk("rst_clr0",  32'(bus0.o_fifo_clr_en), 32'h0);
    chk("rst_busy0", 32'(bus0.o_grp_busy),    32'h0);
    chk("rst_to1",   32'(bus1.o_grp_timeout), 32'h0);
    chk("rst_clr2",  32'(bus2.o_fifo_clr_en), 32'h0);
    chk("rst_clr3",  32'(bus3.o_fifo_clr_en), 32'h0);
`ifdef HSSTHP_FIFO_CLR_STATS_EN
    chk("rst_cnt0",  32'(bus0.o_clr_cnt),     32'h0);
`endif
    bus2.i_fifo_clr_req = '0;
    rst_n = 1'b1;
    tick(9);

    // Test 1: rise at cycle 10 with done=11 -> pulse visible cycles 29..32.
    bus0.i_rxlane_done = 4'b0011;
    bus0.i_cdr_align[0] = 1'b1;
    for (int c = 11; c <= 36; c++) begin
      tick();
      chk($sformatf("t1_clr_c%0d", c), 32'(bus0.o_fifo_clr_en),
          (c >= 29 && c <= 32) ? 32'h3 : 32'h0);
      if (c == 11) chk("t1_busy_wait", 32'(bus0.o_grp_busy), 32'h1);
    end
    chk("t1_busy_done", 32'(bus0.o_grp_busy), 32'h0);

    // Soft reset during CLEAR: clear drops next cycle, FSM idles, no new pulse.
    bus0.i_cdr_align[0] = 1'b0;
    tick(2);
    bus0.i_cdr_align[0] = 1'b1;
    found = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (bus0.o_fifo_clr_en[0]) begin
        found = 1;
        break;
      end
    end
    chk("t4_wait_clear", 32'(found), 32'h1);
    tick();
    bus0.i_lane_srst[1] = 1'b1;
    tick();
    bus0.i_lane_srst[1] = 1'b0;
    chk("t4_clr_off",  32'(bus0.o_fifo_clr_en), 32'h0);
    chk("t4_idle",     32'(bus0.o_grp_busy),    32'h0);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (bus0.o_fifo_clr_en != 4'b0000 || bus0.o_grp_busy[0]) seen = 1;
    end
    chk("t4_quiet", 32'(seen), 32'h0);

`ifdef HSSTHP_FIFO_CLR_STATS_EN
    // 300 clear sequences on group 0 saturate its counter; soft reset zeroes it.
    chk("st_cnt_after_srst", 32'(bus0.o_clr_cnt[7:0]), 32'h0);
    for (int i = 0; i < 300; i++) begin
      bus0.i_cdr_align[0] = 1'b0;
      tick(2);
      bus0.i_cdr_align[0] = 1'b1;
      tick(23);
      if (i == 9) chk("st_cnt10", 32'(bus0.o_clr_cnt[7:0]), 32'd10);
    end
    chk("st_cnt_sat", 32'(bus0.o_clr_cnt[7:0]), 32'd255);
    chk("st_cnt_g1",  32'(bus0.o_clr_cnt[15:8]), 32'h0);
    bus0.i_lane_srst[0] = 1'b1;
    tick();
    bus0.i_lane_srst[0] = 1'b0;
    chk("st_cnt_srst", 32'(bus0.o_clr_cnt[7:0]), 32'h0);
`endif

    // Watchdog: lane 3 never done, abort 100 cycles after WAIT_DONE entry.
    bus1.i_rxlane_done = 4'b0111;
    bus1.i_cdr_align[2] = 1'b1;
    n_to = 0; to_k = 0; seen = 0;
    for (int k = 1; k <= 110; k++) begin
      tick();
      if (bus1.o_grp_timeout[0]) begin
        n_to++;
        to_k = k;
      end
      if (bus1.o_fifo_clr_en != 4'b0000) seen = 1;
      if (k == 1) chk("to_busy", 32'(bus1.o_grp_busy), 32'h1);
    end
    chk("to_pulses", 32'(n_to), 32'd1);
    chk("to_cycle",  32'(to_k), 32'd101);
    chk("to_noclr",  32'(seen), 32'h0);
    chk("to_idle",   32'(bus1.o_grp_busy), 32'h0);

    // Bypass group 1: request passes through one cycle late, group stays idle.
    bus2.i_fifo_clr_req = 4'b1000;
    for (int k = 1; k <= 6; k++) begin
      tick();
      chk($sformatf("byp_clr_k%0d", k), 32'(bus2.o_fifo_clr_en),
          (k <= 3) ? 32'h8 : 32'h0);
      chk($sformatf("byp_busy_k%0d", k), 32'(bus2.o_grp_busy[1]), 32'h0);
      if (k == 3) bus2.i_fifo_clr_req = 4'b0000;
    end

    // RX-enable mask: lane 0 ignored, lane 1 yields a 4-cycle pulse alone.
    bus3.i_rxlane_done = 4'b1111;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      bus3.i_cdr_align[0] = ~bus3.i_cdr_align[0];
      for (int j = 0; j < 3; j++) begin
        tick();
        if (bus3.o_fifo_clr_en[0] || bus3.o_grp_busy[0]) seen = 1;
      end
    end
    chk("msk_lane0_quiet", 32'(seen), 32'h0);
    bus3.i_cdr_align[1] = 1'b1;
    for (int k = 1; k <= 25; k++) begin
      tick();
      chk($sformatf("msk_clr_k%0d", k), 32'(bus3.o_fifo_clr_en),
          (k >= 19 && k <= 22) ? 32'h2 : 32'h0);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
